decryptor: RTL and testbench

Byte-serial streaming decryptor: the receive-side inverse of the team's Polybius/keyword encryptor. It accepts one cipher byte per handshake and subtracts the running key value (key "NEDELCU" over the 5×5 table, no "J"). It maps valid Polybius codes back to uppercase letters and passes all other bytes through. It sits between the cipher-byte link and the plaintext consumer and tracks message boundaries and key position internally.

---
 rtl/decryptor_pkg.sv | 31 +++
 rtl/polybius_decode.sv | 28 ++
 rtl/decryptor.sv | 109 ++++++++++
 tb/tb_decryptor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/decryptor_pkg.sv
`default_nettype none
// =============================================================================
// Module      : decryptor_pkg
// Description : Shared constants and types for the Polybius/keyword decryptor.
// Revision    : 1.0 - initial release
// =============================================================================
package decryptor_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Row/column numbering starts at 1 so cipher digits index directly.
    localparam logic [7:0] C_TABLE [1:5][1:5] = '{
        '{"R", "A", "E", "S", "B"},
        '{"C", "D", "F", "G", "H"},
        '{"I", "K", "L", "M", "N"},
        '{"O", "P", "Q", "T", "U"},
        '{"V", "W", "X", "Y", "Z"}
    };

    localparam logic [8*7-1:0] C_KEY = "NEDELCU";

    // Polybius code (row*10 + col) of each key character above.
    localparam logic [7:0] C_KEY_VAL [0:6] = '{
        8'd35, 8'd13, 8'd22, 8'd13, 8'd33, 8'd21, 8'd45
    };

endpackage : decryptor_pkg
`default_nettype wire

// File: rtl/polybius_decode.sv
`default_nettype none
// =============================================================================
// Module      : polybius_decode
// Description : Combinational Polybius code -> letter lookup with hit flag.
// Revision    : 1.0 - initial release
// =============================================================================
module polybius_decode
    import decryptor_pkg::*;
(
    input  logic [7:0] v,
    output logic [7:0] letter,
    output logic       hit
);

    logic [7:0] w_tens;
    logic [7:0] w_units;

    assign w_tens  = v / 8'd10;
    assign w_units = v % 8'd10;

    // Both digits in 1..5 already bounds v to 11..55.
    assign hit = (w_tens  >= 8'd1) && (w_tens  <= 8'd5) &&
                 (w_units >= 8'd1) && (w_units <= 8'd5);

    assign letter = hit ? C_TABLE[w_tens[2:0]][w_units[2:0]] : v;

endmodule : polybius_decode
`default_nettype wire

// File: rtl/decryptor.sv
`default_nettype none
// =============================================================================
// Module      : decryptor
// Description : Byte-serial keyword/Polybius decryptor with valid/ready links.
//               Optional passthrough counter enabled by DECRYPTOR_PASSCNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module decryptor
    import decryptor_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int SEC_LEN = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last
`ifdef DECRYPTOR_PASSCNT_EN
    ,
    output logic [15:0] pass_cnt
`endif
);

    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam int CW = $clog2(MSG_LEN + 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [KW-1:0] r_key_idx;
    logic [KW-1:0] w_key_sel;
    logic [CW-1:0] r_char_cnt;
    logic          w_accept;
    logic          w_msg_end;
    logic [7:0]    w_v;
    logic [7:0]    w_letter;
    logic          w_hit;

    assign s_ready   = !m_valid || m_ready;
    assign w_accept  = s_valid && s_ready;
    assign w_msg_end = s_last || (r_char_cnt == CW'(MSG_LEN - 1));

    // A fresh message always starts at the first key character.
    assign w_key_sel = (r_state == IDLE) ? '0 : r_key_idx;
    assign w_v       = s_data - C_KEY_VAL[w_key_sel];

    polybius_decode u_decode (
        .v      (w_v),
        .letter (w_letter),
        .hit    (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) w_state_next = w_msg_end ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_idx  <= '0;
            r_char_cnt <= '0;
        end else if (w_accept) begin
            if (w_msg_end) begin
                r_key_idx  <= '0;
                r_char_cnt <= '0;
            end else begin
                r_char_cnt <= r_char_cnt + CW'(1);
                r_key_idx  <= (w_key_sel == KW'(SEC_LEN - 1)) ? '0 : w_key_sel + KW'(1);
            end
        end
    end

    // Output register: reloads on accept even while the old byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
        end else if (w_accept) begin
            m_valid <= 1'b1;
            m_data  <= w_letter;
            m_last  <= w_msg_end;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef DECRYPTOR_PASSCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= 16'h0000;
        end else if (w_accept && !w_hit && (pass_cnt != 16'hFFFF)) begin
            pass_cnt <= pass_cnt + 16'd1;
        end
    end
`endif

endmodule : decryptor
`default_nettype wire

// File: tb/tb_decryptor.sv
`default_nettype none
// =============================================================================
// Module      : tb_decryptor
// Description : Directed self-checking bench for the decryptor.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_decryptor;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
`ifdef DECRYPTOR_PASSCNT_EN
    logic [15:0] pass_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Independent copy of the key values (N E D E L C U).
    logic [7:0] kv [0:6] = '{8'd35, 8'd13, 8'd22, 8'd13, 8'd33, 8'd21, 8'd45};

    always #5 clk = ~clk;

    decryptor #(.MSG_LEN(16), .SEC_LEN(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
`ifdef DECRYPTOR_PASSCNT_EN
        ,
        .pass_cnt (pass_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, then advance one clock and settle.
    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data",  32'(m_data),  32'h00);
        check("reset_m_last",  32'(m_last),  32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;

        // Two-byte message: 60-35=25 -> H, 44-13=31 -> I
        drive(1'b1, 8'd60, 1'b0, 1'b1);
        check("msg1_b0_valid", 32'(m_valid), 32'd1);
        check("msg1_b0_data",  32'(m_data),  32'("H"));
        check("msg1_b0_last",  32'(m_last),  32'd0);
        drive(1'b1, 8'd44, 1'b1, 1'b1);
        check("msg1_b1_data",  32'(m_data),  32'("I"));
        check("msg1_b1_last",  32'(m_last),  32'd1);

        // Eight R's back to back; eighth byte wraps to key index 0
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'd11 + kv[i % 7], (i == 7), 1'b1);
            check("wrap_r_data", 32'(m_data), 32'("R"));
            check("wrap_r_last", 32'(m_last), 32'(i == 7));
        end

        // Passthrough and collisions, each a single-byte message at key N
        drive(1'b1, 8'd81, 1'b1, 1'b1);
        check("pass_dot",  32'(m_data), 32'h2E);
        check("pass_last", 32'(m_last), 32'd1);
        drive(1'b1, 8'd67, 1'b1, 1'b1);
        check("space_k",   32'(m_data), 32'("K"));
        drive(1'b1, 8'd200, 1'b1, 1'b1);
        check("lower_a5",  32'(m_data), 32'hA5);
        drive(1'b1, 8'd90, 1'b1, 1'b1);
        check("edge_z",    32'(m_data), 32'("Z"));
        drive(1'b1, 8'd45, 1'b1, 1'b1);
        check("units0_pass", 32'(m_data), 32'd10);
`ifdef DECRYPTOR_PASSCNT_EN
        check("pass_cnt", 32'(pass_cnt), 32'd3);
`endif

        // Backpressure: H held while 44 waits, then I, then A (12+22=34)
        drive(1'b1, 8'd60, 1'b0, 1'b1);
        check("bp_first", 32'(m_data), 32'("H"));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'd44, 1'b0, 1'b0);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_hold",    32'(m_data),  32'("H"));
            check("bp_valid",   32'(m_valid), 32'd1);
        end
        drive(1'b1, 8'd44, 1'b0, 1'b1);
        check("bp_resume_i", 32'(m_data), 32'("I"));
        drive(1'b1, 8'd34, 1'b1, 1'b1);
        check("bp_resume_a", 32'(m_data), 32'("A"));
        check("bp_last",     32'(m_last), 32'd1);

        // Sixteen bytes without s_last close the message on the 16th
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'd11 + kv[i % 7], 1'b0, 1'b1);
            check("len_data", 32'(m_data), 32'("R"));
            check("len_last", 32'(m_last), 32'(i == 15));
        end
        drive(1'b1, 8'd46, 1'b1, 1'b1);
        check("len_17th_key0", 32'(m_data), 32'("R"));

        // Reset mid-message drops output and restarts the key
        drive(1'b1, 8'd46, 1'b0, 1'b1);
        drive(1'b1, 8'd24, 1'b0, 1'b1);
        drive(1'b1, 8'd33, 1'b0, 1'b1);
        check("rst_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 8'd24, 1'b0, 1'b1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'h00);
        rst = 1'b0;
        drive(1'b1, 8'd60, 1'b1, 1'b1);
        check("rst_key0_h", 32'(m_data), 32'("H"));
        drive(1'b0, 8'd00, 1'b0, 1'b1);
        check("drain_valid", 32'(m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decryptor
`default_nettype wire
